dht11_sample_reporter: RTL and testbench

Periodic polling and reporting stage that sits directly downstream of the DHT11 sensor controller. It issues a one-cycle `dht_start` every `POLL_MS` milliseconds and waits for `dht_done`, with a timeout. It latches validated humidity and temperature bytes and streams an ASCII report frame, one byte at a time, over a valid/ready byte interface into the UART transmitter.

---
 rtl/dht11_sample_reporter_if.sv | 19 +
 rtl/dht11_sample_reporter.sv | 230 +++++++++++++++++++++++
 tb/tb_dht11_sample_reporter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_sample_reporter_if.sv
// Byte stream from the sample reporter into the UART transmitter.
// Valid/ready handshake: a byte moves on a rising edge with both high.
interface dht11_sample_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/dht11_sample_reporter.sv
// Polls the DHT11 controller, latches good readings, streams ASCII frames.
// Define DHT_REPORT_FRAC_EN to add fraction digits to the data frame.
module dht11_sample_reporter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int POLL_MS    = 2000,
  parameter int TIMEOUT_MS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        dht_start,
  input  logic        dht_done,
  input  logic        dht_valid,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  dht11_sample_reporter_if.master tx,
  output logic [7:0]  hum_out,
  output logic [7:0]  temp_out,
  output logic        sample_valid,
  output logic [7:0]  err_cnt
);

  localparam int DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int TW  = $clog2(DIV > 1 ? DIV : 2);
  localparam int PW  = $clog2(POLL_MS + 1);
  localparam int OW  = $clog2(TIMEOUT_MS + 1);

`ifdef DHT_REPORT_FRAC_EN
  localparam logic [3:0] LAST_DATA = 4'd14;
`else
  localparam logic [3:0] LAST_DATA = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_DONE,
    SEND
  } state_t;

  state_t      state;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] poll_cnt;
  logic [OW-1:0] to_cnt;
  logic        tick;
  logic        poll_wrap;
  logic        pending;
  logic        frame_err;
  logic [3:0]  idx;
  logic [3:0]  nidx;
  logic [3:0]  last_idx;
  logic [7:0]  nbyte;
  logic [7:0]  data_q;
  logic        valid_q;

`ifdef DHT_REPORT_FRAC_EN
  logic [7:0]  hum_frac;
  logic [7:0]  temp_frac;
`else
  logic        unused_frac;
  assign unused_frac = ^{humidity[7:0], temperature[7:0]};
`endif

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  function automatic logic [7:0] tens(input logic [7:0] v);
    return 8'h30 + clamp99(v) / 8'd10;
  endfunction

  function automatic logic [7:0] units(input logic [7:0] v);
    return 8'h30 + clamp99(v) % 8'd10;
  endfunction

  assign tick      = (tick_cnt == TW'(DIV - 1));
  assign poll_wrap = enable && tick
                  && (poll_cnt == PW'(POLL_MS - 1));
  assign last_idx  = frame_err ? 4'd4 : LAST_DATA;

  // Byte that follows the one currently on the bus.
  always_comb begin
    nidx  = idx + 4'd1;
    nbyte = 8'h0A;
    if (frame_err) begin
      case (nidx)
        4'd1, 4'd2: nbyte = "R";
        4'd3:       nbyte = 8'h0D;
        default:    nbyte = 8'h0A;
      endcase
    end else begin
      case (nidx)
        4'd1:    nbyte = "=";
        4'd2:    nbyte = tens(hum_out);
        4'd3:    nbyte = units(hum_out);
`ifdef DHT_REPORT_FRAC_EN
        4'd4:    nbyte = ".";
        4'd5:    nbyte = units(hum_frac);
        4'd6:    nbyte = " ";
        4'd7:    nbyte = "T";
        4'd8:    nbyte = "=";
        4'd9:    nbyte = tens(temp_out);
        4'd10:   nbyte = units(temp_out);
        4'd11:   nbyte = ".";
        4'd12:   nbyte = units(temp_frac);
        4'd13:   nbyte = 8'h0D;
`else
        4'd4:    nbyte = " ";
        4'd5:    nbyte = "T";
        4'd6:    nbyte = "=";
        4'd7:    nbyte = tens(temp_out);
        4'd8:    nbyte = units(temp_out);
        4'd9:    nbyte = 8'h0D;
`endif
        default: nbyte = 8'h0A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      poll_cnt     <= '0;
      to_cnt       <= '0;
      pending      <= 1'b0;
      dht_start    <= 1'b0;
      frame_err    <= 1'b0;
      idx          <= '0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      hum_out      <= 8'h00;
      temp_out     <= 8'h00;
      sample_valid <= 1'b0;
      err_cnt      <= 8'h00;
`ifdef DHT_REPORT_FRAC_EN
      hum_frac     <= 8'h00;
      temp_frac    <= 8'h00;
`endif
    end else begin
      dht_start <= 1'b0;

      if (!enable) begin
        poll_cnt <= '0;
      end else if (tick) begin
        poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
      end

      // Expirations while busy collapse into this single flag.
      if (!enable) begin
        pending <= 1'b0;
      end else if (poll_wrap) begin
        pending <= 1'b1;
      end else if (state == IDLE) begin
        pending <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (pending && enable) begin
            state     <= TRIG;
            dht_start <= 1'b1;
          end
        end
        TRIG: begin
          to_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (dht_done) begin
            idx     <= '0;
            valid_q <= 1'b1;
            state   <= SEND;
            if (dht_valid) begin
              hum_out      <= humidity[15:8];
              temp_out     <= temperature[15:8];
              sample_valid <= 1'b1;
              frame_err    <= 1'b0;
              data_q       <= "H";
`ifdef DHT_REPORT_FRAC_EN
              hum_frac     <= humidity[7:0];
              temp_frac    <= temperature[7:0];
`endif
            end else begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              frame_err <= 1'b1;
              data_q    <= "E";
            end
          end else if (tick) begin
            if (to_cnt == OW'(TIMEOUT_MS - 1)) begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              frame_err <= 1'b1;
              data_q    <= "E";
              valid_q   <= 1'b1;
              idx       <= '0;
              state     <= SEND;
            end else begin
              to_cnt <= to_cnt + OW'(1);
            end
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            if (idx == last_idx) begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end else begin
              idx    <= nidx;
              data_q <= nbyte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sample_reporter.sv
// Bench for dht11_sample_reporter: vector table plus byte scoreboard.
// Expected frames switch with DHT_REPORT_FRAC_EN.
module tb_dht11_sample_reporter;

  localparam int CLK_HZ     = 10_000;
  localparam int POLL_MS    = 20;
  localparam int TIMEOUT_MS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        dht_done = 1'b0;
  logic        dht_valid = 1'b0;
  logic [15:0] humidity = 16'h0;
  logic [15:0] temperature = 16'h0;
  logic        dht_start;
  logic [7:0]  hum_out;
  logic [7:0]  temp_out;
  logic        sample_valid;
  logic [7:0]  err_cnt;

  dht11_sample_reporter_if txb ();

  dht11_sample_reporter #(
    .CLK_HZ     (CLK_HZ),
    .POLL_MS    (POLL_MS),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .dht_start    (dht_start),
    .dht_done     (dht_done),
    .dht_valid    (dht_valid),
    .humidity     (humidity),
    .temperature  (temperature),
    .tx           (txb),
    .hum_out      (hum_out),
    .temp_out     (temp_out),
    .sample_valid (sample_valid),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  byte unsigned exp_q[$];
  int cyc = 0;
  int start_count = 0;
  int last_start_cyc = 0;
  int first_valid_cyc = 0;
  int bp_mode = 0;
  int seen = 0;
  logic prev_start = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h0;

  typedef struct {
    logic        valid;
    logic        timeout;
    logic [15:0] hum;
    logic [15:0] temp;
    int          bp;
    logic [7:0]  exp_h;
    logic [7:0]  exp_t;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t  vecs[6];
  string frames[6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input int limit);
    int n = 0;
    while (start_count <= seen && n < limit) begin
      step();
      n++;
    end
    if (start_count <= seen) begin
      checks++;
      failures++;
      $display("FAIL start_wait: no dht_start in %0d cycles", limit);
    end
    seen = start_count;
  endtask

  task automatic wait_frame(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || txb.tx_valid) && n < limit) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || txb.tx_valid) begin
      checks++;
      failures++;
      $display("FAIL frame_wait: %0d bytes left", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drives tx_ready for the coming edge, then scores what that edge moves.
  always @(negedge clk) begin
    cyc++;
    case (bp_mode)
      1:       txb.tx_ready = (cyc % 4 == 0);
      2:       txb.tx_ready = 1'b0;
      default: txb.tx_ready = 1'b1;
    endcase
    if (rst) begin
      prev_start = 1'b0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (dht_start) begin
        start_count++;
        last_start_cyc = cyc;
        check("start_width", 32'(prev_start), 32'd0);
      end
      if (prev_stall && txb.tx_valid)
        check("hold", 32'(txb.tx_data), 32'(prev_data));
      if (txb.tx_valid && !prev_valid) first_valid_cyc = cyc;
      if (txb.tx_valid && txb.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte: got %0h expected none", txb.tx_data);
        end else begin
          check("byte", 32'(txb.tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_start = dht_start;
      prev_stall = txb.tx_valid && !txb.tx_ready;
      prev_data  = txb.tx_data;
      prev_valid = txb.tx_valid;
    end
  end

  initial begin
    int prev_sc;
    int d;
    int sc;

    vecs[0] = '{1'b1, 1'b0, 16'h3700, 16'h1A05, 0, 8'h37, 8'h1A, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 16'h1111, 16'h2222, 0, 8'h37, 8'h1A, 8'd1};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 0, 8'h37, 8'h1A, 8'd2};
    vecs[3] = '{1'b1, 1'b0, 16'h2D00, 16'h1700, 1, 8'h2D, 8'h17, 8'd2};
    vecs[4] = '{1'b1, 1'b0, 16'h9C00, 16'h0500, 0, 8'h9C, 8'h05, 8'd2};
    vecs[5] = '{1'b1, 1'b0, 16'h0A63, 16'h00FF, 0, 8'h0A, 8'h00, 8'd2};
`ifdef DHT_REPORT_FRAC_EN
    frames[0] = "H=55.0 T=26.5";
    frames[3] = "H=45.0 T=23.0";
    frames[4] = "H=99.0 T=05.0";
    frames[5] = "H=10.9 T=00.9";
`else
    frames[0] = "H=55 T=26";
    frames[3] = "H=45 T=23";
    frames[4] = "H=99 T=05";
    frames[5] = "H=10 T=00";
`endif
    frames[1] = "ERR";
    frames[2] = "ERR";

    txb.tx_ready = 1'b1;
    repeat (3) step();
    check("rst_start", 32'(dht_start), 32'd0);
    check("rst_valid", 32'(txb.tx_valid), 32'd0);
    check("rst_data", 32'(txb.tx_data), 32'd0);
    check("rst_hum", 32'(hum_out), 32'd0);
    check("rst_temp", 32'(temp_out), 32'd0);
    check("rst_sample", 32'(sample_valid), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    prev_sc = 0;
    for (int i = 0; i < 6; i++) begin
      bp_mode = vecs[i].bp;
      wait_start(400);
      if (i > 0)
        check("period", 32'(last_start_cyc - prev_sc), 32'd200);
      prev_sc = last_start_cyc;
      if (vecs[i].timeout) begin
        push_frame(frames[i]);
        wait_frame(300);
        d = first_valid_cyc - last_start_cyc;
        check("timeout_lat", 32'(d >= 40 && d <= 52), 32'd1);
      end else begin
        repeat (3) step();
        dht_done    = 1'b1;
        dht_valid   = vecs[i].valid;
        humidity    = vecs[i].hum;
        temperature = vecs[i].temp;
        push_frame(frames[i]);
        step();
        check("lat_valid", 32'(txb.tx_valid), 32'd1);
        check("lat_hum", 32'(hum_out), 32'(vecs[i].exp_h));
        step();
        dht_done  = 1'b0;
        dht_valid = 1'b0;
        wait_frame(300);
      end
      check("hum_out", 32'(hum_out), 32'(vecs[i].exp_h));
      check("temp_out", 32'(temp_out), 32'(vecs[i].exp_t));
      check("err_cnt", 32'(err_cnt), 32'(vecs[i].exp_err));
      check("sample_valid", 32'(sample_valid), 32'd1);
      bp_mode = 0;
    end

    // A long run of bad reads must pin the error counter.
    for (int k = 0; k < 300; k++) begin
      wait_start(400);
      push_frame("ERR");
      dht_done  = 1'b1;
      dht_valid = 1'b0;
      repeat (2) step();
      dht_done = 1'b0;
    end
    wait_frame(300);
    check("err_sat", 32'(err_cnt), 32'd255);
    check("sat_hum", 32'(hum_out), 32'h0A);

    // Enable drops mid-frame: frame completes, no further polls.
    wait_start(400);
    repeat (2) step();
    dht_done    = 1'b1;
    dht_valid   = 1'b1;
    humidity    = 16'h0100;
    temperature = 16'h0200;
`ifdef DHT_REPORT_FRAC_EN
    push_frame("H=01.0 T=02.0");
`else
    push_frame("H=01 T=02");
`endif
    repeat (2) step();
    dht_done  = 1'b0;
    dht_valid = 1'b0;
    enable    = 1'b0;
    wait_frame(300);
    check("dis_hum", 32'(hum_out), 32'h01);
    sc = start_count;
    repeat (500) step();
    check("dis_nostart", 32'(start_count), 32'(sc));
    check("dis_idle", 32'(txb.tx_valid), 32'd0);

    // Reset while a frame is stalled on tx_ready.
    seen = start_count;
    enable = 1'b1;
    wait_start(400);
    bp_mode = 2;
    repeat (2) step();
    dht_done    = 1'b1;
    dht_valid   = 1'b1;
    humidity    = 16'h3700;
    temperature = 16'h1A05;
    repeat (2) step();
    dht_done  = 1'b0;
    dht_valid = 1'b0;
    step();
    check("stall_valid", 32'(txb.tx_valid), 32'd1);
    check("stall_data", 32'(txb.tx_data), 32'h48);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(txb.tx_valid), 32'd0);
    check("mid_rst_data", 32'(txb.tx_data), 32'd0);
    check("mid_rst_hum", 32'(hum_out), 32'd0);
    check("mid_rst_temp", 32'(temp_out), 32'd0);
    check("mid_rst_sample", 32'(sample_valid), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_start", 32'(dht_start), 32'd0);
    exp_q.delete();
    step();
    step();
    check("in_rst_valid", 32'(txb.tx_valid), 32'd0);
    rst = 1'b0;
    bp_mode = 0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
